// File: rtl/tbus_ddr_arbiter.sv
// ============================================================================
// Module  : tbus_ddr_arbiter
// Brief   : icache/dcache to DDR tbus arbiter, one outstanding transaction.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TBUS_READ
`define TBUS_READ  2'd1
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'd2
`endif

module tbus_ddr_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ARB_MODE   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  icache2arb_tbus_index_valid,
  output logic                  icache2arb_tbus_index_ready,
  input  logic [ADDR_WIDTH-1:0] icache2arb_tbus_index,
  input  logic [1:0]            icache2arb_tbus_operation_type,
  output logic [DATA_WIDTH-1:0] icache2arb_tbus_read_data,
  output logic                  icache2arb_tbus_operation_done,
  input  logic                  dcache2arb_tbus_index_valid,
  output logic                  dcache2arb_tbus_index_ready,
  input  logic [ADDR_WIDTH-1:0] dcache2arb_tbus_index,
  input  logic [DATA_WIDTH-1:0] dcache2arb_tbus_write_data,
  input  logic [DATA_WIDTH-1:0] dcache2arb_tbus_write_mask,
  input  logic [1:0]            dcache2arb_tbus_operation_type,
  output logic [DATA_WIDTH-1:0] dcache2arb_tbus_read_data,
  output logic                  dcache2arb_tbus_operation_done,
  output logic                  arb2ddr_tbus_index_valid,
  input  logic                  arb2ddr_tbus_index_ready,
  output logic [ADDR_WIDTH-1:0] arb2ddr_tbus_index,
  output logic [DATA_WIDTH-1:0] arb2ddr_tbus_write_data,
  output logic [DATA_WIDTH-1:0] arb2ddr_tbus_write_mask,
  output logic [1:0]            arb2ddr_tbus_operation_type,
  input  logic [DATA_WIDTH-1:0] arb2ddr_tbus_read_data,
  input  logic                  arb2ddr_tbus_operation_done
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic                  last_grant;   // 1 = dcache
  logic                  owner;        // 1 = dcache
  logic [ADDR_WIDTH-1:0] lat_index;
  logic [1:0]            lat_op;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] lat_wmask;
  logic [DATA_WIDTH-1:0] resp_data;

  logic pick_d;
  logic pick_i;
  logic accept;
  logic capture;

  // dcache wins when alone, in fixed-priority mode, or when icache had the last grant
  assign pick_d = dcache2arb_tbus_index_valid &
                  (~icache2arb_tbus_index_valid | (ARB_MODE != 0) | ~last_grant);
  assign pick_i = icache2arb_tbus_index_valid & ~pick_d;
  assign accept = (state == IDLE) & ~reset & (pick_d | pick_i);
  assign capture = arb2ddr_tbus_operation_done &
                   (((state == ISSUE) & arb2ddr_tbus_index_ready) | (state == WAIT_DONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = ISSUE;
      ISSUE:     if (arb2ddr_tbus_index_ready)
                   state_next = arb2ddr_tbus_operation_done ? RESP : WAIT_DONE;
      WAIT_DONE: if (arb2ddr_tbus_operation_done) state_next = RESP;
      RESP:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b0;
      owner      <= 1'b0;
      lat_index  <= '0;
      lat_op     <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
      resp_data  <= '0;
    end else begin
      if (accept) begin
        last_grant <= pick_d;
        owner      <= pick_d;
        lat_index  <= pick_d ? dcache2arb_tbus_index : icache2arb_tbus_index;
        lat_op     <= pick_d ? dcache2arb_tbus_operation_type
                             : icache2arb_tbus_operation_type;
        lat_wdata  <= pick_d ? dcache2arb_tbus_write_data : '0;
        lat_wmask  <= pick_d ? dcache2arb_tbus_write_mask : '0;
      end
      if (capture) begin
        resp_data <= (lat_op == `TBUS_READ) ? arb2ddr_tbus_read_data : '0;
      end
    end
  end

  always_comb begin
    icache2arb_tbus_index_ready    = (state == IDLE) & ~reset & pick_i;
    dcache2arb_tbus_index_ready    = (state == IDLE) & ~reset & pick_d;
    arb2ddr_tbus_index_valid       = 1'b0;
    arb2ddr_tbus_index             = '0;
    arb2ddr_tbus_write_data        = '0;
    arb2ddr_tbus_write_mask        = '0;
    arb2ddr_tbus_operation_type    = '0;
    icache2arb_tbus_operation_done = 1'b0;
    icache2arb_tbus_read_data      = '0;
    dcache2arb_tbus_operation_done = 1'b0;
    dcache2arb_tbus_read_data      = '0;
    if (!reset) begin
      if (state == ISSUE) begin
        arb2ddr_tbus_index_valid    = 1'b1;
        arb2ddr_tbus_index          = lat_index;
        arb2ddr_tbus_write_data     = lat_wdata;
        arb2ddr_tbus_write_mask     = lat_wmask;
        arb2ddr_tbus_operation_type = lat_op;
      end
      if (state == RESP) begin
        if (owner) begin
          dcache2arb_tbus_operation_done = 1'b1;
          dcache2arb_tbus_read_data      = resp_data;
        end else begin
          icache2arb_tbus_operation_done = 1'b1;
          icache2arb_tbus_read_data      = resp_data;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tbus_ddr_arbiter.sv
// ============================================================================
// Module  : tb_tbus_ddr_arbiter
// Brief   : Directed vector bench for tbus_ddr_arbiter (round-robin and fixed priority).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TBUS_READ
`define TBUS_READ  2'd1
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'd2
`endif

module tb_tbus_ddr_arbiter;

  localparam logic [1:0] RD = `TBUS_READ;
  localparam logic [1:0] WR = `TBUS_WRITE;

  logic        clock = 1'b0;
  logic        reset;
  logic        iv, dv, rdy, dn;
  logic [63:0] ii, di, dwd, dwm, rd;
  logic [1:0]  iop, dop;

  logic        ir0, dr0, v0, id0, dd0;
  logic [63:0] ird0, drd0, idx0, wd0, wm0;
  logic [1:0]  op0;
  logic        ir1, dr1, v1, id1, dd1;
  logic [63:0] ird1, drd1, idx1, wd1, wm1;
  logic [1:0]  op1;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  tbus_ddr_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ARB_MODE(0)) dut0 (
    .clock(clock), .reset(reset),
    .icache2arb_tbus_index_valid(iv), .icache2arb_tbus_index_ready(ir0),
    .icache2arb_tbus_index(ii), .icache2arb_tbus_operation_type(iop),
    .icache2arb_tbus_read_data(ird0), .icache2arb_tbus_operation_done(id0),
    .dcache2arb_tbus_index_valid(dv), .dcache2arb_tbus_index_ready(dr0),
    .dcache2arb_tbus_index(di), .dcache2arb_tbus_write_data(dwd),
    .dcache2arb_tbus_write_mask(dwm), .dcache2arb_tbus_operation_type(dop),
    .dcache2arb_tbus_read_data(drd0), .dcache2arb_tbus_operation_done(dd0),
    .arb2ddr_tbus_index_valid(v0), .arb2ddr_tbus_index_ready(rdy),
    .arb2ddr_tbus_index(idx0), .arb2ddr_tbus_write_data(wd0),
    .arb2ddr_tbus_write_mask(wm0), .arb2ddr_tbus_operation_type(op0),
    .arb2ddr_tbus_read_data(rd), .arb2ddr_tbus_operation_done(dn)
  );

  tbus_ddr_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ARB_MODE(1)) dut1 (
    .clock(clock), .reset(reset),
    .icache2arb_tbus_index_valid(iv), .icache2arb_tbus_index_ready(ir1),
    .icache2arb_tbus_index(ii), .icache2arb_tbus_operation_type(iop),
    .icache2arb_tbus_read_data(ird1), .icache2arb_tbus_operation_done(id1),
    .dcache2arb_tbus_index_valid(dv), .dcache2arb_tbus_index_ready(dr1),
    .dcache2arb_tbus_index(di), .dcache2arb_tbus_write_data(dwd),
    .dcache2arb_tbus_write_mask(dwm), .dcache2arb_tbus_operation_type(dop),
    .dcache2arb_tbus_read_data(drd1), .dcache2arb_tbus_operation_done(dd1),
    .arb2ddr_tbus_index_valid(v1), .arb2ddr_tbus_index_ready(rdy),
    .arb2ddr_tbus_index(idx1), .arb2ddr_tbus_write_data(wd1),
    .arb2ddr_tbus_write_mask(wm1), .arb2ddr_tbus_operation_type(op1),
    .arb2ddr_tbus_read_data(rd), .arb2ddr_tbus_operation_done(dn)
  );

  typedef struct {
    logic        iv;  logic [63:0] ii;  logic [1:0] iop;
    logic        dv;  logic [63:0] di;  logic [1:0] dop;
    logic [63:0] dwd; logic [63:0] dwm;
    logic        rdy; logic        dn;  logic [63:0] rd;
    logic        e_ir; logic       e_dr; logic      e_v;
    logic [63:0] e_idx; logic [1:0] e_op; logic [63:0] e_wd; logic [63:0] e_wm;
    logic        e_id; logic [63:0] e_ird; logic      e_dd; logic [63:0] e_drd;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    iv = 0; ii = '0; iop = '0; dv = 0; di = '0; dop = '0;
    dwd = '0; dwm = '0; rdy = 0; dn = 0; rd = '0;
  endtask

  task automatic chk_quiet0(input string tag);
    chk({tag, ".v"},  {63'd0, v0},  64'd0);
    chk({tag, ".id"}, {63'd0, id0}, 64'd0);
    chk({tag, ".dd"}, {63'd0, dd0}, 64'd0);
    chk({tag, ".ir"}, {63'd0, ir0}, 64'd0);
    chk({tag, ".dr"}, {63'd0, dr0}, 64'd0);
  endtask

  initial begin
    //         iv ii     iop dv di             dop dwd       dwm       rdy dn rd                      e_ir e_dr e_v e_idx          e_op e_wd    e_wm   e_id e_ird  e_dd e_drd
    tbl[0]  = '{0, 64'h0,  0, 1, 64'h8000_1040, RD, 64'h0,    64'h0,    0, 0, 64'h0,                   0, 1, 0, 64'h0,          0,  64'h0,    64'h0,  0, 64'h0,  0, 64'h0};
    tbl[1]  = '{0, 64'h0,  0, 0, 64'h0,         0,  64'h0,    64'h0,    1, 0, 64'h0,                   0, 0, 1, 64'h8000_1040,  RD, 64'h0,    64'h0,  0, 64'h0,  0, 64'h0};
    tbl[2]  = '{0, 64'h0,  0, 0, 64'h0,         0,  64'h0,    64'h0,    0, 0, 64'h0,                   0, 0, 0, 64'h0,          0,  64'h0,    64'h0,  0, 64'h0,  0, 64'h0};
    tbl[3]  = '{0, 64'h0,  0, 0, 64'h0,         0,  64'h0,    64'h0,    0, 1, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 64'h0,          0,  64'h0,    64'h0,  0, 64'h0,  0, 64'h0};
    tbl[4]  = '{0, 64'h0,  0, 0, 64'h0,         0,  64'h0,    64'h0,    0, 0, 64'h0,                   0, 0, 0, 64'h0,          0,  64'h0,    64'h0,  0, 64'h0,  1, 64'hDEAD_BEEF_0000_0001};
    tbl[5]  = '{0, 64'h0,  0, 0, 64'h0,         0,  64'h0,    64'h0,    1, 1, 64'h3333,                0, 0, 0, 64'h0,          0,  64'h0,    64'h0,  0, 64'h0,  0, 64'h0};
    tbl[6]  = '{0, 64'h0,  0, 1, 64'h2000,      WR, 64'h1234, 64'hFF,   0, 0, 64'h0,                   0, 1, 0, 64'h0,          0,  64'h0,    64'h0,  0, 64'h0,  0, 64'h0};
    tbl[7]  = '{0, 64'h0,  0, 0, 64'h0,         0,  64'h0,    64'h0,    1, 1, 64'h5555,                0, 0, 1, 64'h2000,       WR, 64'h1234, 64'hFF, 0, 64'h0,  0, 64'h0};
    tbl[8]  = '{0, 64'h0,  0, 0, 64'h0,         0,  64'h0,    64'h0,    0, 0, 64'h0,                   0, 0, 0, 64'h0,          0,  64'h0,    64'h0,  0, 64'h0,  1, 64'h0};
    tbl[9]  = '{1, 64'h40, RD, 0, 64'h0,        0,  64'hAAAA, 64'hFFFF, 0, 0, 64'h0,                   1, 0, 0, 64'h0,          0,  64'h0,    64'h0,  0, 64'h0,  0, 64'h0};
    tbl[10] = '{0, 64'h0,  0, 0, 64'h0,         0,  64'hAAAA, 64'hFFFF, 0, 0, 64'h0,                   0, 0, 1, 64'h40,         RD, 64'h0,    64'h0,  0, 64'h0,  0, 64'h0};
    tbl[11] = '{0, 64'h0,  0, 0, 64'h0,         0,  64'h0,    64'h0,    1, 0, 64'h0,                   0, 0, 1, 64'h40,         RD, 64'h0,    64'h0,  0, 64'h0,  0, 64'h0};
    tbl[12] = '{0, 64'h0,  0, 0, 64'h0,         0,  64'h0,    64'h0,    0, 1, 64'h77,                  0, 0, 0, 64'h0,          0,  64'h0,    64'h0,  0, 64'h0,  0, 64'h0};
    tbl[13] = '{0, 64'h0,  0, 0, 64'h0,         0,  64'h0,    64'h0,    0, 0, 64'h0,                   0, 0, 0, 64'h0,          0,  64'h0,    64'h0,  1, 64'h77, 0, 64'h0};
    tbl[14] = '{0, 64'h0,  0, 0, 64'h0,         0,  64'h0,    64'h0,    0, 0, 64'h0,                   0, 0, 0, 64'h0,          0,  64'h0,    64'h0,  0, 64'h0,  0, 64'h0};

    // Reset with both masters requesting: every output must stay low.
    idle_inputs();
    reset = 1; iv = 1; dv = 1;
    @(negedge clock); #2;
    chk_quiet0("reset");
    chk("reset.dut1_dr", {63'd0, dr1}, 64'd0);
    @(negedge clock);
    reset = 0; idle_inputs();

    // Table: dcache read, dcache writeback, icache read with backpressure.
    for (int i = 0; i < 15; i++) begin
      iv = tbl[i].iv; ii = tbl[i].ii; iop = tbl[i].iop;
      dv = tbl[i].dv; di = tbl[i].di; dop = tbl[i].dop;
      dwd = tbl[i].dwd; dwm = tbl[i].dwm;
      rdy = tbl[i].rdy; dn = tbl[i].dn; rd = tbl[i].rd;
      #2;
      chk($sformatf("vec%0d.ir", i), {63'd0, ir0}, {63'd0, tbl[i].e_ir});
      chk($sformatf("vec%0d.dr", i), {63'd0, dr0}, {63'd0, tbl[i].e_dr});
      chk($sformatf("vec%0d.v",  i), {63'd0, v0},  {63'd0, tbl[i].e_v});
      if (tbl[i].e_v) begin
        chk($sformatf("vec%0d.idx", i), idx0, tbl[i].e_idx);
        chk($sformatf("vec%0d.op",  i), {62'd0, op0}, {62'd0, tbl[i].e_op});
        chk($sformatf("vec%0d.wd",  i), wd0, tbl[i].e_wd);
        chk($sformatf("vec%0d.wm",  i), wm0, tbl[i].e_wm);
      end
      chk($sformatf("vec%0d.id",  i), {63'd0, id0}, {63'd0, tbl[i].e_id});
      chk($sformatf("vec%0d.ird", i), ird0, tbl[i].e_ird);
      chk($sformatf("vec%0d.dd",  i), {63'd0, dd0}, {63'd0, tbl[i].e_dd});
      chk($sformatf("vec%0d.drd", i), drd0, tbl[i].e_drd);
      @(negedge clock);
    end

    // Both masters held valid across four transactions after a fresh reset:
    // round-robin alternates d,i,d,i; fixed priority always picks dcache.
    idle_inputs();
    reset = 1;
    @(negedge clock);
    reset = 0;
    iv = 1; ii = 64'h1000; iop = RD; dv = 1; di = 64'h2000; dop = RD;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("rr%0d.dr0", k), {63'd0, dr0}, {63'd0, (k % 2) == 0});
      chk($sformatf("rr%0d.ir0", k), {63'd0, ir0}, {63'd0, (k % 2) == 1});
      chk($sformatf("fp%0d.dr1", k), {63'd0, dr1}, 64'd1);
      chk($sformatf("fp%0d.ir1", k), {63'd0, ir1}, 64'd0);
      @(negedge clock);
      rdy = 1; dn = 1; rd = 64'h100 + 64'(k);
      #2;
      chk($sformatf("rr%0d.idx", k), idx0, ((k % 2) == 0) ? 64'h2000 : 64'h1000);
      chk($sformatf("fp%0d.idx", k), idx1, 64'h2000);
      @(negedge clock);
      rdy = 0; dn = 0; rd = '0;
      #2;
      chk($sformatf("rr%0d.dd", k), {63'd0, dd0}, {63'd0, (k % 2) == 0});
      chk($sformatf("rr%0d.id", k), {63'd0, id0}, {63'd0, (k % 2) == 1});
      chk($sformatf("rr%0d.rdat", k), ((k % 2) == 0) ? drd0 : ird0, 64'h100 + 64'(k));
      chk($sformatf("rr%0d.resp_rdy", k), {62'd0, ir0, dr0}, 64'd0);
      chk($sformatf("fp%0d.dd", k), {63'd0, dd1}, 64'd1);
      @(negedge clock);
    end
    idle_inputs();
    @(negedge clock);

    // DDR backpressure: payload held, no new acceptance.
    dv = 1; di = 64'h3000; dop = WR; dwd = 64'hBEEF; dwm = 64'hF0;
    #2;
    chk("bp.accept", {63'd0, dr0}, 64'd1);
    @(negedge clock);
    idle_inputs();
    iv = 1; ii = 64'h4000; iop = RD;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk($sformatf("bp%0d.v", c), {63'd0, v0}, 64'd1);
      chk($sformatf("bp%0d.idx", c), idx0, 64'h3000);
      chk($sformatf("bp%0d.wd", c), wd0, 64'hBEEF);
      chk($sformatf("bp%0d.wm", c), wm0, 64'hF0);
      chk($sformatf("bp%0d.rdy", c), {62'd0, ir0, dr0}, 64'd0);
      @(negedge clock);
    end
    iv = 0; rdy = 1;
    #2;
    chk("bp.release_v", {63'd0, v0}, 64'd1);
    @(negedge clock);
    rdy = 0;
    @(negedge clock);
    dn = 1; rd = 64'h999;
    @(negedge clock);
    dn = 0; rd = '0;
    #2;
    chk("bp.dd", {63'd0, dd0}, 64'd1);
    chk("bp.drd", drd0, 64'd0);
    chk("bp.id", {63'd0, id0}, 64'd0);
    @(negedge clock);

    // Reset in WAIT_DONE with DDR done arriving right after: no response.
    dv = 1; di = 64'h5000; dop = RD;
    @(negedge clock);
    dv = 0; rdy = 1;
    @(negedge clock);
    rdy = 0;
    #2;
    chk("rst.wait_v", {63'd0, v0}, 64'd0);
    @(negedge clock);
    reset = 1;
    #2;
    chk_quiet0("rst.during");
    @(negedge clock);
    reset = 0; dn = 1; rd = 64'hBAD;
    #2;
    chk_quiet0("rst.after1");
    @(negedge clock);
    dn = 0; rd = '0;
    #2;
    chk_quiet0("rst.after2");
    @(negedge clock);
    iv = 1; ii = 64'h6000; iop = RD;
    #2;
    chk("rst.idle_accept", {63'd0, ir0}, 64'd1);
    @(negedge clock);
    idle_inputs();
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
